// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment patterns and blank codes.
package seg7_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [3:0] BCD_BLANK = 4'hF;
  // Index n holds the {g,f,e,d,c,b,a} pattern for decimal digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
endpackage

// File: rtl/seg7_decode.sv
// BCD to 7-segment decoder; codes above 9 produce a dark digit.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    if (bcd < 4'd10) seg = SEG_TABLE[bcd];
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with frame-synchronous display update.
// Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  pending
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);

  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic                   tick, frame;
  logic [DIGITS-1:0][3:0] act_bcd, pend_bcd;
  logic [DIGITS-1:0]      act_dp, pend_dp;
  logic [3:0]             cur_bcd;
  logic [6:0]             dec_seg;
  logic                   blank;

  assign tick  = (cnt == CW'(SCAN_DIV - 1));
  assign frame = tick && (idx == IW'(DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  // A load landing on the frame boundary bypasses the pending stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_bcd  <= {DIGITS{BCD_BLANK}};
      pend_bcd <= {DIGITS{BCD_BLANK}};
      act_dp   <= '0;
      pend_dp  <= '0;
      pending  <= 1'b0;
    end else if (load && frame) begin
      act_bcd <= bcd_in;
      act_dp  <= dp_in;
      pending <= 1'b0;
    end else begin
      if (frame && pending) begin
        act_bcd <= pend_bcd;
        act_dp  <= pend_dp;
        pending <= 1'b0;
      end
      if (load) begin
        pend_bcd <= bcd_in;
        pend_dp  <= dp_in;
        pending  <= 1'b1;
      end
    end
  end

  assign cur_bcd = act_bcd[idx];

  seg7_decode u_dec (.bcd(cur_bcd), .seg(dec_seg));

`ifdef SEG7_LZB_EN
  // zrun[k]: digit k and every digit above it are zero.
  logic [DIGITS-1:1] zrun;
  logic [DIGITS-1:0] lzb;
  assign lzb[0] = 1'b0;
  for (genvar k = 1; k < DIGITS; k++) begin : g_lzb
    if (k == DIGITS - 1) begin : g_top
      assign zrun[k] = (act_bcd[k] == 4'd0);
    end else begin : g_low
      assign zrun[k] = (act_bcd[k] == 4'd0) && zrun[k+1];
    end
    assign lzb[k] = zrun[k] && !act_dp[k];
  end
  assign blank = lzb[idx];
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_BLANK;
      dp  <= 1'b0;
      an  <= '0;
    end else begin
      seg <= blank ? SEG_BLANK : dec_seg;
      dp  <= act_dp[idx];
      an  <= DIGITS'(1) << idx;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed, table-driven bench for seg7_scan_driver (DIGITS=4, SCAN_DIV=4).
module tb_seg7_scan_driver;
  logic        clk = 1'b0;
  logic        rst_n, load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        pending;

  int checks = 0;
  int fails  = 0;

  seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .seg(seg), .dp(dp), .an(an), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     bcd;
    logic [3:0]      dpv;
    logic [3:0][6:0] es;
    logic [3:0]      ed;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s[%0d] got=%0h exp=%0h", nm, id, got, exp);
    end
  endtask

  task automatic wait_an(input logic [3:0] pat);
    int n = 0;
    while (an !== pat && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (an !== pat) begin
      checks++;
      fails++;
      $display("FAIL wait_an got=%0h exp=%0h", an, pat);
    end
  endtask

  task automatic do_load(input logic [15:0] b, input logic [3:0] d);
    bcd_in = b;
    dp_in  = d;
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  // Checks one full frame, starting at the next frame's first digit slot.
  task automatic check_frame(input logic [3:0][6:0] es, input logic [3:0] ed, input int id);
    wait_an(4'b1000);
    wait_an(4'b0001);
    chk("frame_pending", id, 32'(pending), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("frame_an", id * 10 + k, 32'(an), 32'(1 << k));
      chk("frame_seg", id * 10 + k, 32'(seg), 32'(es[k]));
      chk("frame_dp", id * 10 + k, 32'(dp), 32'(ed[k]));
      if (k < 3) repeat (4) @(negedge clk);
    end
  endtask

  task automatic scan_blank(input int n, input int id);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("scan_an", id * 100 + i, 32'(an), 32'(1 << ((i / 4) % 4)));
      chk("scan_seg", id * 100 + i, 32'(seg), 32'd0);
      chk("scan_dp", id * 100 + i, 32'(dp), 32'd0);
      chk("scan_pending", id * 100 + i, 32'(pending), 32'd0);
    end
  endtask

  initial begin
    vt[0] = '{16'h1234, 4'b0100, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0100};
    vt[1] = '{16'hA9F0, 4'b0000, {7'h00, 7'h6F, 7'h00, 7'h3F}, 4'b0000};
    vt[2] = '{16'h5678, 4'b1001, {7'h6D, 7'h7D, 7'h07, 7'h7F}, 4'b1001};
`ifdef SEG7_LZB_EN
    vt[3] = '{16'h0070, 4'b0000, {7'h00, 7'h00, 7'h07, 7'h3F}, 4'b0000};
    vt[4] = '{16'h0000, 4'b0000, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000};
    vt[5] = '{16'h0000, 4'b1000, {7'h3F, 7'h00, 7'h00, 7'h3F}, 4'b1000};
    vt[6] = '{16'h0500, 4'b0000, {7'h00, 7'h6D, 7'h3F, 7'h3F}, 4'b0000};
`else
    vt[3] = '{16'h0070, 4'b0000, {7'h3F, 7'h3F, 7'h07, 7'h3F}, 4'b0000};
    vt[4] = '{16'h0000, 4'b0000, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000};
    vt[5] = '{16'h0000, 4'b1000, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b1000};
    vt[6] = '{16'h0500, 4'b0000, {7'h3F, 7'h6D, 7'h3F, 7'h3F}, 4'b0000};
`endif

    rst_n  = 1'b0;
    load   = 1'b0;
    bcd_in = '0;
    dp_in  = '0;
    repeat (3) @(negedge clk);
    chk("rst_an", 0, 32'(an), 32'd0);
    chk("rst_seg", 0, 32'(seg), 32'd0);
    chk("rst_dp", 0, 32'(dp), 32'd0);
    chk("rst_pending", 0, 32'(pending), 32'd0);

    rst_n = 1'b1;
    scan_blank(20, 0);

    // Mid-frame loads commit at the next frame boundary.
    for (int i = 0; i < 7; i++) begin
      wait_an(4'b0010);
      do_load(vt[i].bcd, vt[i].dpv);
      chk("load_pending", i, 32'(pending), 32'd1);
      check_frame(vt[i].es, vt[i].ed, i);
    end

    // Two loads in one frame: only the last is shown.
    wait_an(4'b0010);
    do_load(16'h5678, 4'b0000);
    chk("coll_pending1", 0, 32'(pending), 32'd1);
    wait_an(4'b0100);
    do_load(16'h9012, 4'b0000);
    wait_an(4'b1000);
    chk("coll_pending2", 0, 32'(pending), 32'd1);
    chk("coll_old_seg", 0, 32'(seg), 32'(vt[6].es[3]));
    check_frame({7'h6F, 7'h3F, 7'h06, 7'h5B}, 4'b0000, 20);

    // Load on the exact boundary cycle goes straight to the active register.
    wait_an(4'b0100);
    wait_an(4'b1000);
    repeat (2) @(negedge clk);
    do_load(16'h4321, 4'b0001);
    chk("bnd_pending", 0, 32'(pending), 32'd0);
    check_frame({7'h66, 7'h4F, 7'h5B, 7'h06}, 4'b0001, 21);

    // Reset with data pending: outputs clear immediately, load ignored, blank afterward.
    wait_an(4'b0010);
    do_load(16'h8888, 4'b1111);
    chk("mid_pending", 0, 32'(pending), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an", 0, 32'(an), 32'd0);
    chk("arst_seg", 0, 32'(seg), 32'd0);
    chk("arst_dp", 0, 32'(dp), 32'd0);
    chk("arst_pending", 0, 32'(pending), 32'd0);
    bcd_in = 16'h1111;
    dp_in  = 4'b1111;
    load   = 1'b1;
    repeat (2) @(negedge clk);
    load   = 1'b0;
    chk("rstload_pending", 0, 32'(pending), 32'd0);
    rst_n = 1'b1;
    scan_blank(32, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-002 SHALL have parameter SCAN_DIV, default 50000: clock cycles per digit slot, minimum 2.
REQ-003 SHALL have port clk  in  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port load  in  1: single-cycle request to capture new display data.
REQ-006 SHALL have port bcd_in  in  4*DIGITS: packed BCD; digit k is bcd_in[4k+3:4k], and digit 0 is rightmost.
REQ-007 SHALL have port dp_in  in  DIGITS: decimal point per digit, active-high.
REQ-008 SHALL have port seg  out  7: segments {g,f,e,d,c,b,a}, active-high.
REQ-009 SHALL have port dp  out  1: decimal point of the currently selected digit.
REQ-010 SHALL have port an  out  DIGITS: one-hot digit select, active-high.
REQ-011 SHALL have port pending  out  1: captured data is waiting for the next frame boundary.

Function
REQ-012 SHALL count a prescaler from 0 to SCAN_DIV-1 and wrap; the terminal count is "tick".
REQ-013 SHALL advance a digit index on tick from 0 to DIGITS-1, wrapping to 0; the wrap from DIGITS-1 to 0 is the "frame boundary".
REQ-014 SHALL register seg, dp and an, which reflect the index and active data of the previous cycle (1-cycle latency).
REQ-015 SHALL drive an = 1<<index, so exactly one bit is high after the first post-reset edge.
REQ-016 SHALL decode digits 0-9 to the standard patterns 0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F; codes 0xA-0xF SHALL blank (seg=0).
REQ-017 SHALL copy bcd_in/dp_in into a pending register and set pending on load.
REQ-018 SHALL, at a frame boundary with pending=1, copy the pending register into the active register and clear pending.
REQ-019 SHALL let a load while pending=1 overwrite the pending data; only the last load before the boundary is displayed.
REQ-020 SHALL, when load coincides with a frame boundary, write the load data directly to the active register and leave pending=0.
REQ-021 SHALL ignore load while rst_n=0.

Reset
REQ-022 SHALL, on rst_n low, immediately clear the prescaler, index, seg, dp, an and pending to 0.
REQ-023 SHALL, on rst_n low, set every active and pending digit to 4'hF (blank) and every dp bit to 0.
REQ-024 SHALL discard any in-flight pending data when reset is asserted mid-frame; no partial update survives.

Configuration
REQ-025 SHALL, with SEG7_LZB_EN defined, blank leading zeros: any digit k>0 whose value and all higher digits' values are 0 and whose dp is 0 SHALL output seg=0; digit 0 is never blanked.
REQ-026 SHALL, without SEG7_LZB_EN, display every digit 0-9 as decoded, and the leading-zero logic SHALL be absent.

Structure
REQ-027 SHALL take the segment pattern constants, SEG_BLANK (7'h00) and BCD_BLANK (4'hF) from a shared package seg7_pkg.
REQ-028 SHALL instantiate one combinational sub-module, seg7_decode (4-bit in, 7-bit out, per REQ-016).

Verification (DIGITS=4, SCAN_DIV=4 unless stated)
REQ-029 SHALL verify reset/scan: release rst_n -> an cycles 0001,0010,0100,1000,0001 every 4 clocks, with seg=0 throughout.
REQ-030 SHALL verify load/commit: load bcd_in=16'h1234, dp_in=4'b0100 mid-frame -> pending=1 until the boundary; the next frame shows 0x66,0x4F,0x5B,0x06 on an 0001..1000, with dp=1 only on an=0100.
REQ-031 SHALL verify load collision: load 16'h5678 then 16'h9012 in the same frame -> the next frame shows 9012 only; load exactly on the boundary cycle -> displayed that frame, with pending=0.
REQ-032 SHALL verify invalid codes: bcd_in=16'hA9F0 -> digits 3 and 1 blank, digit 2 = 0x6F, digit 0 = 0x3F.
REQ-033 SHALL verify leading-zero blanking (SEG7_LZB_EN): 16'h0070 -> digits 3 and 2 blank, digits 1 and 0 shown; 16'h0000 -> only digit 0 shown; setting dp_in[3]=1 shows digit 3.
REQ-034 SHALL verify reset mid-operation: assert rst_n during pending=1 -> all outputs 0 asynchronously; after release, blank frames until a new load.
